// File: rtl/sha3_result_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : sha3_result_scanner_if
// Description : Found-result handshake between the SHA3 result scanner and
//               the AXI front-end that drains winning nonce/hash pairs.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha3_result_scanner_if #(
  parameter int NONCE_WIDTH = 32
);
  logic                   found_valid;
  logic                   found_ready;
  logic [NONCE_WIDTH-1:0] found_nonce;
  logic [63:0]            found_hash;

  // Scanner side: presents the FIFO head
  modport master (
    output found_valid,
    output found_nonce,
    output found_hash,
    input  found_ready
  );

  // Consumer side: accepts the FIFO head
  modport slave (
    input  found_valid,
    input  found_nonce,
    input  found_hash,
    output found_ready
  );
endinterface
`default_nettype wire

// File: rtl/sha3_result_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sha3_result_scanner
// Description : Counts result strobes from the iterating SHA3 pipe, rebuilds
//               each nonce from the job base, compares the hash word against
//               a difficulty threshold and queues winners in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_result_scanner #(
  parameter int FIFO_DEPTH  = 4,
  parameter int NONCE_WIDTH = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   start,
  input  wire logic [NONCE_WIDTH-1:0] base_nonce,
  input  wire logic [NONCE_WIDTH-1:0] scan_count,
  input  wire logic [63:0]            threshold,
  input  wire logic                   igood,
  input  wire logic [63:0]            ihash,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 dropped,
  sha3_result_scanner_if.master       found
);

  localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]  c_DEPTH = FIFO_DEPTH[c_PTR_W:0];
  localparam int                c_ENT_W = NONCE_WIDTH + 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [NONCE_WIDTH-1:0] r_base;
  logic [NONCE_WIDTH-1:0] r_scan_count;
  logic [63:0]            r_threshold;
  logic [NONCE_WIDTH-1:0] r_processed;

  logic                   r_s1_valid;
  logic [63:0]            r_s1_hash;
  logic [NONCE_WIDTH-1:0] r_s1_nonce;
  logic                   r_s2_win;
  logic [63:0]            r_s2_hash;
  logic [NONCE_WIDTH-1:0] r_s2_nonce;

  logic [c_ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W:0]       r_fifo_cnt;
  logic                   r_found_valid;
  logic [NONCE_WIDTH-1:0] r_found_nonce;
  logic [63:0]            r_found_hash;
  logic [15:0]            r_dropped;

  logic                   w_take;
  logic [NONCE_WIDTH-1:0] w_proc_inc;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;
  logic                   w_drop;
  logic [c_PTR_W:0]       w_cnt_after_pop;
  logic [c_PTR_W:0]       w_cnt_next;
  logic [c_PTR_W-1:0]     w_rd_next;
  logic [c_ENT_W-1:0]     w_head_next;

  assign w_take     = (r_state == S_SCAN) && igood;
  assign w_proc_inc = r_processed + 1'b1;

  // Job control, nonce reconstruction (stage 1) and threshold compare (stage 2)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_base       <= '0;
      r_scan_count <= '0;
      r_threshold  <= '0;
      r_processed  <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_hash    <= '0;
      r_s1_nonce   <= '0;
      r_s2_win     <= 1'b0;
      r_s2_hash    <= '0;
      r_s2_nonce   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_hash  <= ihash;
        r_s1_nonce <= r_base + r_processed;
      end
      // Stage 2 only carries winners; losers simply vanish here
      r_s2_win   <= r_s1_valid && (r_s1_hash <= r_threshold);
      r_s2_hash  <= r_s1_hash;
      r_s2_nonce <= r_s1_nonce;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base       <= base_nonce;
            r_scan_count <= scan_count;
            r_threshold  <= threshold;
            r_processed  <= '0;
            r_busy       <= 1'b1;
            r_state      <= (scan_count == '0) ? S_FLUSH : S_SCAN;
          end
        end
        S_SCAN: begin
          if (igood) begin
            r_processed <= w_proc_inc;
            if (w_proc_inc == r_scan_count) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Both pipe stages must drain so every winner reaches the FIFO
          if (!r_s1_valid && !r_s2_win) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop           = r_found_valid && found.found_ready;
  assign w_full          = (r_fifo_cnt == c_DEPTH);
  // A pop frees the slot the push lands in, so full+pop still accepts
  assign w_push          = r_s2_win && (!w_full || w_pop);
  assign w_drop          = r_s2_win && w_full && !w_pop;
  assign w_cnt_after_pop = r_fifo_cnt - {{c_PTR_W{1'b0}}, w_pop};
  assign w_cnt_next      = w_cnt_after_pop + {{c_PTR_W{1'b0}}, w_push};
  assign w_rd_next       = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_pop};
  // When the FIFO is otherwise empty the incoming winner becomes the head
  assign w_head_next     = (w_cnt_after_pop == '0) ? {r_s2_nonce, r_s2_hash}
                                                   : r_mem[w_rd_next];

  // FIFO storage; pointer bookkeeping alone defines occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s2_nonce, r_s2_hash};
    end
  end

  // FIFO pointers, registered head outputs and the saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_fifo_cnt    <= '0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_dropped     <= '0;
    end else begin
      r_rd_ptr      <= w_rd_next;
      r_fifo_cnt    <= w_cnt_next;
      r_found_valid <= (w_cnt_next != '0);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_cnt_next != '0) begin
        {r_found_nonce, r_found_hash} <= w_head_next;
      end
      if (w_drop && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign dropped           = r_dropped;
  assign found.found_valid = r_found_valid;
  assign found.found_nonce = r_found_nonce;
  assign found.found_hash  = r_found_hash;

endmodule
`default_nettype wire

// File: tb/tb_sha3_result_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_result_scanner
// Description : Directed self-checking bench for sha3_result_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_result_scanner;

  localparam int c_NW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [c_NW-1:0] base_nonce;
  logic [c_NW-1:0] scan_count;
  logic [63:0]     threshold;
  logic            igood;
  logic [63:0]     ihash;
  logic            busy;
  logic            done;
  logic [15:0]     dropped;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [95:0] q_pop [$];

  sha3_result_scanner_if #(.NONCE_WIDTH(c_NW)) fif ();

  sha3_result_scanner #(.FIFO_DEPTH(4), .NONCE_WIDTH(c_NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_nonce (base_nonce),
    .scan_count (scan_count),
    .threshold  (threshold),
    .igood      (igood),
    .ihash      (ihash),
    .busy       (busy),
    .done       (done),
    .dropped    (dropped),
    .found      (fif.master)
  );

  always #5 clk = ~clk;

  // Record every accepted head entry and every done pulse
  always @(negedge clk) begin
    if (!rst && fif.found_valid && fif.found_ready)
      q_pop.push_back({fif.found_nonce, fif.found_hash});
    if (!rst && done)
      done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [31:0] c, input logic [63:0] t);
    start      = 1'b1;
    base_nonce = b;
    scan_count = c;
    threshold  = t;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input logic [63:0] h);
    igood = 1'b1;
    ihash = h;
    tick();
    igood = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      tick();
      cyc++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_pops(input string tag, input logic [31:0] en [$], input logic [63:0] eh [$]);
    check({tag, "_count"}, 64'(q_pop.size()), 64'(en.size()));
    for (int i = 0; i < en.size() && i < q_pop.size(); i++) begin
      check($sformatf("%s_nonce%0d", tag, i), 64'(q_pop[i][95:64]), 64'(en[i]));
      check($sformatf("%s_hash%0d", tag, i), q_pop[i][63:0], eh[i]);
    end
  endtask

  initial begin
    int cyc;
    int d0;
    logic [31:0] en [$];
    logic [63:0] eh [$];

    rst = 1'b1; start = 1'b0; base_nonce = '0; scan_count = '0;
    threshold = '0; igood = 1'b0; ihash = '0; fif.found_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(fif.found_valid), 64'd0);
    check("rst_nonce", 64'(fif.found_nonce), 64'd0);
    check("rst_hash", fif.found_hash, 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);

    // Job 1: base 100, 8 back-to-back results, accept all
    fif.found_ready = 1'b1;
    start_job(32'd100, 32'd8, '1);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      igood = 1'b1;
      ihash = 64'hA000 + 64'(i);
      tick();
      if (i == 1) check("t1_lat_n2", 64'(fif.found_valid), 64'd0);
      if (i == 2) begin
        check("t1_lat_n3", 64'(fif.found_valid), 64'd1);
        check("t1_lat_nonce", 64'(fif.found_nonce), 64'd100);
      end
    end
    igood = 1'b0;
    wait_done(20, cyc);
    repeat (6) tick();
    en.delete(); eh.delete();
    for (int i = 0; i < 8; i++) begin
      en.push_back(32'd100 + 32'(i));
      eh.push_back(64'hA000 + 64'(i));
    end
    expect_pops("t1", en, eh);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_dropped", 64'(dropped), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Job 2: nonce wrap around 2^32
    q_pop.delete();
    start_job(32'hFFFF_FFFE, 32'd4, '1);
    for (int i = 0; i < 4; i++) feed(64'h77 + 64'(i));
    wait_done(20, cyc);
    repeat (6) tick();
    en = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    eh = '{64'h77, 64'h78, 64'h79, 64'h7A};
    expect_pops("t2", en, eh);

    // Job 3: threshold boundary, hash == threshold wins
    q_pop.delete();
    start_job(32'd0, 32'd4, 64'h10);
    feed(64'h5); feed(64'h10); feed(64'h11); feed(64'h0);
    wait_done(20, cyc);
    repeat (6) tick();
    en = '{32'd0, 32'd1, 32'd3};
    eh = '{64'h5, 64'h10, 64'h0};
    expect_pops("t3", en, eh);

    // Job 4: consumer stalled, FIFO fills, 3 drops
    q_pop.delete();
    fif.found_ready = 1'b0;
    start_job(32'd500, 32'd7, '1);
    for (int i = 0; i < 7; i++) feed(64'hB00 + 64'(i));
    wait_done(20, cyc);
    repeat (3) tick();
    check("t4_dropped", 64'(dropped), 64'd3);
    check("t4_valid", 64'(fif.found_valid), 64'd1);
    check("t4_hold_nonce", 64'(fif.found_nonce), 64'd500);
    repeat (2) tick();
    check("t4_hold_nonce2", 64'(fif.found_nonce), 64'd500);
    check("t4_hold_hash", fif.found_hash, 64'hB00);
    fif.found_ready = 1'b1;
    repeat (8) tick();
    en = '{32'd500, 32'd501, 32'd502, 32'd503};
    eh = '{64'hB00, 64'hB01, 64'hB02, 64'hB03};
    expect_pops("t4", en, eh);
    check("t4_empty", 64'(fif.found_valid), 64'd0);

    // Job 5a: zero-length job
    q_pop.delete();
    d0 = done_cnt;
    start_job(32'd9, 32'd0, '1);
    wait_done(5, cyc);
    check("t5_done_fast", 64'(cyc + 1 <= 3), 64'd1);
    repeat (3) tick();
    check("t5_no_writes", 64'(q_pop.size()), 64'd0);
    check("t5_done_once", 64'(done_cnt - d0), 64'd1);

    // Job 5b: second start while busy is ignored
    d0 = done_cnt;
    start_job(32'd1000, 32'd2, '1);
    tick();
    start_job(32'd2000, 32'd5, '1);
    feed(64'h1); feed(64'h2);
    wait_done(20, cyc);
    repeat (6) tick();
    en = '{32'd1000, 32'd1001};
    eh = '{64'h1, 64'h2};
    expect_pops("t5b", en, eh);
    check("t5b_done_once", 64'(done_cnt - d0), 64'd1);
    check("t5b_idle", 64'(busy), 64'd0);

    // Job 6: reset mid-job, then a fresh job; dropped=3 from job 4 is cleared
    fif.found_ready = 1'b0;
    start_job(32'd50, 32'd8, '1);
    feed(64'hC0); feed(64'hC1); feed(64'hC2);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", 64'(fif.found_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_dropped", 64'(dropped), 64'd0);
    repeat (4) tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_still_empty", 64'(fif.found_valid), 64'd0);
    q_pop.delete();
    fif.found_ready = 1'b1;
    start_job(32'd7, 32'd2, '1);
    feed(64'hD0); feed(64'hD1);
    wait_done(20, cyc);
    repeat (6) tick();
    en = '{32'd7, 32'd8};
    eh = '{64'hD0, 64'hD1};
    expect_pops("t6", en, eh);
    check("t6_done_once", 64'(done_cnt - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha3_result_scanner.md
Name: sha3_result_scanner

Overview:
Downstream consumer of the 6-round iterating SHA3 pipe. It counts the pipe's result bursts, rebuilds the nonce of each result from a base nonce and arrival order, and compares one 64-bit hash word against a difficulty threshold. Winning nonce/hash pairs go into a small FIFO that the AXI front-end drains over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, number of found-result entries held (power of two, 2..16)
NONCE_WIDTH, 32, width of nonce and scan counters

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; begins a scan job when idle
base_nonce  input  NONCE_WIDTH  nonce of the first result of the job
scan_count  input  NONCE_WIDTH  number of results to examine in the job
threshold  input  64  difficulty target, unsigned
igood  input  1  result-valid strobe from the iterating pipe (ogood)
ihash  input  64  word under test (pipe result row a, lane 0)
busy  output  1  high while a job is active
done  output  1  one-cycle pulse at job completion
found_valid  output  1  FIFO head holds a result
found_ready  input  1  consumer accepts the head this cycle
found_nonce  output  NONCE_WIDTH  nonce of the head entry
found_hash  output  64  hash word of the head entry
dropped  output  16  winners lost to a full FIFO, saturating

Behaviour:
- Reset: busy=0, done=0, found_valid=0, found_nonce=0, found_hash=0, dropped=0, FIFO empty, counters 0, state IDLE. Reset mid-job aborts the job and flushes the FIFO. No done pulse.
- States: IDLE, SCAN, FLUSH.
- IDLE + start: latch base_nonce, scan_count, threshold. Clear processed counter. Go to SCAN (busy=1 next cycle). If scan_count==0, go directly to FLUSH.
- start outside IDLE is ignored. igood in IDLE is ignored.
- SCAN, each cycle with igood=1:
  - stage 1 registers ihash and nonce = latched base + processed (modulo 2^NONCE_WIDTH; wraps silently).
  - processed increments.
  - When processed reaches scan_count, go to FLUSH. igood after that is ignored.
- Stage 2, one cycle after stage 1: winner when hash <= threshold (unsigned). threshold = all-ones therefore accepts every result.
  - Winner and FIFO not full: push {nonce, hash}.
  - Winner and FIFO full, with no pop in the same cycle: drop it and increment dropped (saturates at 16'hFFFF).
  - Push and pop in the same cycle on a full FIFO succeed; nothing is dropped.
- FLUSH: wait for stage 1 and stage 2 to empty (at most 2 cycles). Then done=1 for one cycle, busy=0, return to IDLE.
- FIFO contents survive job end and are poppable in IDLE. A new job does not clear the FIFO or dropped.
- Latency: igood at cycle N with a winning hash gives found_valid=1 at N+3 when the FIFO was empty (1 stage reg, 1 compare reg, 1 FIFO write).
- found_* are registered FIFO-head outputs.
  - A pop occurs when found_valid && found_ready. The next entry, if any, is visible the following cycle.
  - found_nonce and found_hash hold steady while found_valid=1 and found_ready=0.
- Results are assumed in-order. Bursts with gaps are tolerated because counting is per igood strobe, not per cycle.

Test Plan:
- Reset, then start with base_nonce=100, scan_count=8, threshold=64'hFFFF_FFFF_FFFF_FFFF, 8 back-to-back igood, found_ready=1 → found_nonce 100..107 in order; done pulses once; dropped=0.
- base_nonce=32'hFFFF_FFFE, scan_count=4, threshold all-ones → nonces FFFFFFFE, FFFFFFFF, 0, 1.
- threshold=64'h10, hashes {5, 64'h10, 64'h11, 0} from base 0 → winners nonce 0, 1, 3 only; boundary hash==threshold is accepted.
- found_ready=0, threshold all-ones, scan_count=7, FIFO_DEPTH=4 → 4 entries held, dropped=3. Then raise found_ready → the first 4 nonces drain in order.
- scan_count=0 start → done within 3 cycles, no FIFO writes. start while busy → ignored; job count unchanged.
- rst asserted mid-job after 3 igoods → found_valid=0, busy=0, dropped=0. A subsequent job behaves as fresh.
